// File: rtl/yarp_pkg.sv
// Shared yarp types: byte-enable encoding, memory arbiter states and owners,
// plus a helper that sizes the arbiter's response timeout counter.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE_EN_BYTE = 2'b00,
    BYTE_EN_HALF = 2'b01,
    BYTE_EN_WORD = 2'b11
  } byte_en_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_e;

  // A disabled timeout (0) still gets a 1-bit counter so the logic stays legal.
  function automatic int unsigned arb_cnt_width(input int unsigned timeout_cycles);
    if (timeout_cycles == 0) begin
      return 1;
    end
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/yarp_arb_rr2.sv
// Two-requester round-robin picker: on a tie the requester that was not
// granted last wins; the history register moves only on an actual grant.
module yarp_arb_rr2
  import yarp_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_instr,
  input  logic       req_data,
  input  logic       grant,
  input  arb_owner_e grant_owner,
  output arb_owner_e winner,
  output logic       any_req
);

  arb_owner_e last_owner;

  // Resetting to data makes the very first tie go to instruction fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWNER_DATA;
    end else if (grant) begin
      last_owner <= grant_owner;
    end
  end

  always_comb begin
    winner = OWNER_DATA;
    if (req_instr && req_data) begin
      winner = (last_owner == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
    end else if (req_instr) begin
      winner = OWNER_INSTR;
    end
  end

  assign any_req = req_instr | req_data;

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Shares the single SoC memory port between fetch and load/store, one
// outstanding transaction at a time, with a response timeout that reports err.
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = arb_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  arb_owner_e       owner_q;
  arb_owner_e       winner;
  logic             any_req;
  logic             grant_evt;
  logic             timeout_hit;
  logic [31:0]      addr_q;
  logic [1:0]       byte_en_q;
  logic             wr_q;
  logic [31:0]      wr_data_q;
  logic [CNT_W-1:0] cnt_q;

  assign grant_evt   = (state_q == ARB_REQ) && mem_gnt_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  yarp_arb_rr2 u_rr2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_instr   (instr_req_i),
    .req_data    (data_req_i),
    .grant       (grant_evt),
    .grant_owner (owner_q),
    .winner      (winner),
    .any_req     (any_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A real response beats a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_REQ;
      ARB_REQ:  if (mem_gnt_i) state_d = ARB_RESP;
      ARB_RESP: if (mem_rvalid_i || timeout_hit) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Attributes are captured once in idle so requesters may change them freely
  // after that without disturbing the bus transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OWNER_DATA;
      addr_q    <= '0;
      byte_en_q <= '0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      if ((state_q == ARB_IDLE) && any_req) begin
        owner_q <= winner;
        if (winner == OWNER_INSTR) begin
          addr_q    <= instr_addr_i;
          byte_en_q <= BYTE_EN_WORD;
          wr_q      <= 1'b0;
          wr_data_q <= '0;
        end else begin
          addr_q    <= data_addr_i;
          byte_en_q <= data_byte_en_i;
          wr_q      <= data_wr_i;
          wr_data_q <= data_wr_data_i;
        end
      end
      if (grant_evt) begin
        cnt_q <= '0;
      end else if ((state_q == ARB_RESP) && !mem_rvalid_i && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    mem_byte_en_o  = '0;
    mem_wr_o       = 1'b0;
    mem_wr_data_o  = '0;
    instr_gnt_o    = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    data_gnt_o     = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;
    case (state_q)
      ARB_REQ: begin
        mem_req_o     = 1'b1;
        mem_addr_o    = addr_q;
        mem_byte_en_o = byte_en_q;
        mem_wr_o      = wr_q;
        mem_wr_data_o = wr_data_q;
        if (mem_gnt_i) begin
          instr_gnt_o = (owner_q == OWNER_INSTR);
          data_gnt_o  = (owner_q == OWNER_DATA);
        end
      end
      ARB_RESP: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWNER_INSTR) begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = mem_rdata_i;
          end else begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = mem_rdata_i;
          end
        end else if (timeout_hit) begin
          if (owner_q == OWNER_INSTR) begin
            instr_rvalid_o = 1'b1;
            instr_err_o    = 1'b1;
          end else begin
            data_rvalid_o = 1'b1;
            data_err_o    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Scoreboard bench for yarp_mem_arbiter: the stimulus predicts bus requests and
// responses from the arbitration rules, and a monitor compares what appears.
module tb_yarp_mem_arbiter;
  import yarp_pkg::*;

  localparam int TO = 4;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic [1:0]  be;
    logic        wr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    logic        err;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [1:0]  data_byte_en_i = '0;
  logic        data_wr_i = 1'b0;
  logic [31:0] data_wr_data_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wr_data_o;
  logic [1:0]  mem_byte_en_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  bit last_is_data = 1'b1;
  bit pend_i = 1'b0;
  bit pend_d = 1'b0;
  bit late_rv = 1'b0;

  yarp_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_byte_en_i (data_byte_en_i),
    .data_wr_i      (data_wr_i),
    .data_wr_data_i (data_wr_data_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_byte_en_o  (mem_byte_en_o),
    .mem_wr_o       (mem_wr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs_or();
    return mem_addr_o | mem_wr_data_o | instr_rdata_o | data_rdata_o |
           32'({mem_req_o, mem_byte_en_o, mem_wr_o, instr_gnt_o, instr_rvalid_o,
                instr_err_o, data_gnt_o, data_rvalid_o, data_err_o});
  endfunction

  // Monitor: every grant and every response must match the head of its queue.
  always @(negedge clk) begin
    bus_exp_t  e;
    resp_exp_t r;
    if (reset_n) begin
      if (instr_gnt_o || data_gnt_o) begin
        check_output("gnt_exclusive", 32'(instr_gnt_o & data_gnt_o), 32'd0);
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL gnt_unexpected: got instr_gnt=%0b data_gnt=%0b, expected no grant",
                   instr_gnt_o, data_gnt_o);
        end else begin
          e = bus_q.pop_front();
          check_output("gnt_owner_is_data", 32'(data_gnt_o), 32'(e.is_data));
          check_output("bus_req", 32'(mem_req_o), 32'd1);
          check_output("bus_addr", mem_addr_o, e.addr);
          check_output("bus_byte_en", 32'(mem_byte_en_o), 32'(e.be));
          check_output("bus_wr", 32'(mem_wr_o), 32'(e.wr));
          check_output("bus_wr_data", mem_wr_data_o, e.wdata);
        end
      end
      if (instr_rvalid_o || data_rvalid_o) begin
        check_output("rvalid_exclusive", 32'(instr_rvalid_o & data_rvalid_o), 32'd0);
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rvalid_unexpected: got instr_rvalid=%0b data_rvalid=%0b, expected none",
                   instr_rvalid_o, data_rvalid_o);
        end else begin
          r = resp_q.pop_front();
          check_output("resp_owner_is_data", 32'(data_rvalid_o), 32'(r.is_data));
          if (r.is_data) begin
            check_output("resp_rdata", data_rdata_o, r.rdata);
            check_output("resp_err", 32'(data_err_o), 32'(r.err));
            check_output("other_quiet", instr_rdata_o | 32'(instr_err_o), 32'd0);
          end else begin
            check_output("resp_rdata", instr_rdata_o, r.rdata);
            check_output("resp_err", 32'(instr_err_o), 32'(r.err));
            check_output("other_quiet", data_rdata_o | 32'(data_err_o), 32'd0);
          end
        end
      end else begin
        check_output("no_resp_quiet",
                     instr_rdata_o | data_rdata_o | 32'({instr_err_o, data_err_o}), 32'd0);
      end
    end
  end

  task automatic req_cycle_check(input logic [31:0] exp_addr);
    check_output("req_held", 32'(mem_req_o), 32'd1);
    check_output("req_addr_latched", mem_addr_o, exp_addr);
  endtask

  // One transaction: raise requests, play the memory side with grant delay g
  // and response delay k (counted in response cycles), and predict the outcome.
  task automatic apply_stimulus(input bit add_i, input bit add_d,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [1:0] dbe, input bit dwr,
                                input int g, input int k, input logic [31:0] rd,
                                input bit scramble, input bit late, input bit spur_gnt,
                                input bit rv_in_req, input bit spur_rv);
    bit        win_data;
    bit        err;
    bus_exp_t  e;
    resp_exp_t r;
    if (add_i && !pend_i) begin
      pend_i = 1'b1;
      instr_req_i = 1'b1;
      instr_addr_i = ia;
    end
    if (add_d && !pend_d) begin
      pend_d = 1'b1;
      data_req_i = 1'b1;
      data_addr_i = da;
      data_wr_data_i = dwd;
      data_byte_en_i = dbe;
      data_wr_i = dwr;
    end
    mem_rvalid_i = late_rv | spur_rv;
    late_rv = 1'b0;
    if (!pend_i && !pend_d) begin
      tick();
      mem_rvalid_i = 1'b0;
      return;
    end
    win_data = (pend_i && pend_d) ? !last_is_data : pend_d;
    if (win_data) begin
      e = '{1'b1, data_addr_i, data_byte_en_i, data_wr_i, data_wr_data_i};
    end else begin
      e = '{1'b0, instr_addr_i, BYTE_EN_WORD, 1'b0, 32'd0};
    end
    bus_q.push_back(e);
    err = (k >= TO);
    r = '{win_data, err ? 32'd0 : rd, err};
    resp_q.push_back(r);

    tick();
    mem_rvalid_i = 1'b0;
    for (int s = 0; s < g; s++) begin
      req_cycle_check(e.addr);
      if (scramble) begin
        if (win_data) data_addr_i = data_addr_i ^ 32'h0000_7000;
        else          instr_addr_i = instr_addr_i ^ 32'h0000_7000;
      end
      tick();
    end
    req_cycle_check(e.addr);
    mem_gnt_i = 1'b1;
    mem_rvalid_i = rv_in_req;
    mem_rdata_i = $urandom;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    last_is_data = win_data;
    if (win_data) begin
      data_req_i = 1'b0;
      pend_d = 1'b0;
      data_addr_i = $urandom;
      data_wr_data_i = $urandom;
    end else begin
      instr_req_i = 1'b0;
      pend_i = 1'b0;
      instr_addr_i = $urandom;
    end

    for (int idx = 0; idx < TO; idx++) begin
      if (idx == k) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rd;
      end else begin
        mem_gnt_i = spur_gnt;
        mem_rdata_i = $urandom;
      end
      tick();
      mem_rvalid_i = 1'b0;
      mem_gnt_i = 1'b0;
      if (idx == k) break;
    end
    if (err && late) late_rv = 1'b1;
  endtask

  task automatic reset_in_resp();
    instr_req_i = 1'b1;
    instr_addr_i = 32'h0000_5000;
    bus_q.push_back('{1'b0, 32'h0000_5000, BYTE_EN_WORD, 1'b0, 32'd0});
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    instr_req_i = 1'b0;
    tick();
    #1;
    reset_n = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check_output("reset_async_outputs", all_outputs_or(), 32'd0);
    tick();
    reset_n = 1'b1;
    last_is_data = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_rvalid_i = 1'b0;
  endtask

  logic [1:0] be_opts [3];

  initial begin
    be_opts[0] = BYTE_EN_BYTE;
    be_opts[1] = BYTE_EN_HALF;
    be_opts[2] = BYTE_EN_WORD;

    // Reset with every input active: outputs must stay quiet.
    instr_req_i = 1'b1;
    data_req_i = 1'b1;
    mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    #2;
    reset_n = 1'b0;
    #1;
    check_output("reset_outputs", all_outputs_or(), 32'd0);
    tick();
    tick();
    check_output("reset_outputs_held", all_outputs_or(), 32'd0);
    instr_req_i = 1'b0;
    data_req_i = 1'b0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    reset_n = 1'b1;
    tick();

    $display("[TB] fetch only");
    apply_stimulus(1, 0, 32'h0000_1000, 0, 0, 0, 0, 1, 1, 32'h0050_0093, 0, 0, 0, 0, 0);

    $display("[TB] ties after reset");
    apply_stimulus(1, 1, 32'h0000_1004, 32'h0000_2000, 32'hCAFE_F00D, BYTE_EN_WORD, 1,
                   0, 0, 32'h1111_1111, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2222_2222, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 32'h0000_1008, 32'h0000_2004, 32'h1234_5678, BYTE_EN_HALF, 0,
                   0, 0, 32'h3333_3333, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h4444_4444, 0, 0, 0, 0, 0);

    $display("[TB] timeout with late response");
    apply_stimulus(0, 1, 0, 32'h0000_2100, 32'h0, BYTE_EN_WORD, 0,
                   0, 6, 32'h5555_5555, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] response on the last cycle beats the timeout");
    apply_stimulus(1, 0, 32'h0000_1100, 0, 0, 0, 0, 0, TO - 1, 32'h6666_6666, 0, 0, 0, 1, 0);

    $display("[TB] attribute change while stalled");
    apply_stimulus(0, 1, 0, 32'h0000_3000, 32'hA5A5_A5A5, BYTE_EN_BYTE, 1,
                   5, 1, 32'h7777_7777, 1, 0, 0, 0, 0);

    $display("[TB] spurious bus handshakes");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(1, 0, 32'h0000_1200, 0, 0, 0, 0, 0, 3, 32'h8888_8888, 0, 0, 1, 0, 0);

    $display("[TB] reset during response phase");
    reset_in_resp();
    apply_stimulus(1, 1, 32'h0000_1300, 32'h0000_2300, 32'h9999_0000, BYTE_EN_WORD, 1,
                   0, 0, 32'h9999_9999, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA_AAAA, 0, 0, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 120; n++) begin
      apply_stimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom, $urandom, $urandom, be_opts[$urandom_range(0, 2)],
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3), $urandom_range(0, 5), $urandom,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0);
    end
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0, 0);
    end
    for (int n = 0; n < 4; n++) tick();

    check_output("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check_output("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check_output("idle_outputs", all_outputs_or(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
